// File: rtl/cla_sub_serial.sv
// ---------------------------------------------------------------------------
// cla_sub_serial
//   Nibble-serial subtractor: DIFF = A - B - BIN over WIDTH bits, evaluated
//   as A + ~B + ~BIN one 4-bit carry-look-ahead slice per clock. The slice
//   carry is the inverted borrow. Start/busy/done handshake, with
//   NIB = WIDTH/4 cycles from acceptance to the done pulse.
//
//   Optional feature: define CLA_SUB_OVF_EN to add the ovf output
//   (two's-complement overflow of the subtraction).
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted on an edge where busy=0
//   a, b   minuend / subtrahend (WIDTH bits), sampled at acceptance
//   bin    borrow-in, sampled at acceptance
//   busy   high while an operation is in progress
//   done   one-cycle pulse; diff/bout (and ovf) valid from this cycle on
//   diff   A - B - BIN mod 2^WIDTH, held until the next completion
//   bout   borrow-out: 1 iff unsigned A < B + BIN
//   ovf    (CLA_SUB_OVF_EN only) signed overflow of the subtraction
// ---------------------------------------------------------------------------
module cla_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("cla_sub_serial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_inv_reg, res_reg, res_next, diff_reg;
    logic             carry_reg, bout_reg, done_reg;
    logic [CW-1:0]    cnt_reg;
    logic [3:0]       nib_a, nib_b, g, p, sum;
    logic [4:0]       c;
    logic             last;
`ifdef CLA_SUB_OVF_EN
    logic             ovf_reg;
`endif

    // Current nibble of the latched operands; b is stored already inverted.
    assign nib_a = a_reg[{cnt_reg, 2'b00} +: 4];
    assign nib_b = b_inv_reg[{cnt_reg, 2'b00} +: 4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice_bits
            assign g[gi]   = nib_a[gi] & nib_b[gi];
            assign p[gi]   = nib_a[gi] ^ nib_b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Look-ahead carries, all derived from the slice carry-in c[0].
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign last = (cnt_reg == CW'(NIB - 1));

    always_comb begin
        state_next = state_reg;
        // Result with the current slice merged in; on the last slice this is
        // the complete difference that gets published to diff.
        res_next = res_reg;
        res_next[{cnt_reg, 2'b00} +: 4] = sum;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_inv_reg <= '0;
            res_reg   <= '0;
            diff_reg  <= '0;
            carry_reg <= 1'b0;
            bout_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
`ifdef CLA_SUB_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_inv_reg <= ~b;
                        carry_reg <= ~bin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= c[4];
                    if (last) begin
                        cnt_reg  <= '0;
                        diff_reg <= res_next;
                        bout_reg <= ~c[4];
                        done_reg <= 1'b1;
`ifdef CLA_SUB_OVF_EN
                        // Carry into the MSB vs. carry out of it.
                        ovf_reg  <= c[3] ^ c[4];
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef CLA_SUB_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: doc/cla_sub_serial.md
Name: cla_sub_serial

Overview:
- Multi-cycle, nibble-serial subtractor: computes DIFF = A - B - BIN for WIDTH-bit operands, one 4-bit carry-look-ahead slice per clock.
- Inverse-direction companion to the 4-bit CLA adder; reuses the same generate/propagate slice arithmetic on A + ~B + ~BIN.
- Sits in the datapath wherever wide subtraction is needed without a WIDTH-bit combinational chain. Start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge where busy=0
- a  input  WIDTH  minuend, sampled at acceptance
- b  input  WIDTH  subtrahend, sampled at acceptance
- bin  input  1  borrow-in, sampled at acceptance
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; diff/bout valid from this cycle on
- diff  output  WIDTH  result A - B - BIN mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned A < B + BIN

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, diff=0, bout=0, nibble counter=0, internal operand/carry registers=0.
- States:
  - IDLE: on start=1 at edge T0, latch a, b, and carry=~bin. Go to RUN, busy=1, counter=0.
  - RUN: on each edge, run one 4-bit CLA slice on nibble[counter] of a and ~b with the current carry. Write the sum nibble into the internal result register, store the slice carry-out, and increment the counter.
  - Last nibble: the edge that processes nibble NIB-1 (NIB=WIDTH/4), i.e. edge T_NIB, does the following:
    - copies the full result into diff;
    - sets bout = ~final carry;
    - sets done=1 and busy=0;
    - returns to IDLE.
- Latency: done is high in the cycle after edge T_NIB (NIB cycles after acceptance). WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
- Throughput: back-to-back operations are allowed. A start sampled at the edge following the done pulse (busy=0) is accepted, giving one operation per NIB+1 cycles.
- done is high for exactly one cycle and is cleared on the next edge regardless of start.
- diff/bout hold the last result until the next completion. They do not change during RUN, so intermediate nibbles are never visible.
- start while busy=1 is ignored. a/b/bin changes during RUN have no effect.
- Arithmetic:
  - Per slice: g=a&~b, p=a^~b, sum=p^c, and carries by look-ahead: c1=g0|p0c, ... c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c.
  - Borrow = ~carry.
- Reset asserted mid-operation aborts immediately. The operation is lost and outputs return to reset values; no done is produced.

Optional Feature:
- Macro CLA_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0) is added after bout.
  - At completion, ovf = two's-complement signed overflow of A - B - BIN = carry into MSB XOR carry out of MSB of the final slice.
  - ovf holds with diff.
- Undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0235, bin=0 -> done exactly 4 cycles after acceptance, diff=0x0FFF, bout=0; busy high for 4 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
- Back-to-back:
  - Stimulus: start held high; a=0xFFFF, b=0x0000, then a=0x8001, b=0x0001.
  - Response: second op accepted the edge after the first done; done pulses twice, 5 cycles apart; diffs are 0xFFFF then 0x8000.
- Start pulse during RUN with different operands -> ignored; the first result is unchanged and only one done is produced.
- Reset mid-op:
  - Stimulus: assert rst_n=0 two cycles into RUN.
  - Response: busy=0, done=0, diff=0, bout=0 asynchronously, no done afterwards; the next op after release computes correctly.
- With CLA_SUB_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0; a=0x0003, b=0x0001 -> ovf=0. Without the macro: same diffs, and the ovf port is absent.
